// File: rtl/pinmux_arb_pkg.sv
// Shared types and defaults for the pad arbiter: pad ownership states and
// default widths used by pinmux_arb_pad and pinmux_arbiter.
package pinmux_arb_pkg;

  typedef enum logic [1:0] {
    OWN_GPIO   = 2'd0,
    BRK_P      = 2'd1,
    OWN_PERIPH = 2'd2,
    BRK_G      = 2'd3
  } pad_state_e;

  localparam int NPIN_DEFAULT   = 5;
  localparam int GW_DEFAULT     = 4;
  localparam int CONFLICT_CNT_W = 16;

endpackage

// File: rtl/pinmux_arb_pad.sv
// One shared pad: ownership FSM with a hi-Z guard counter between GPIO and
// peripheral ownership. Outputs decode only the registered state.
module pinmux_arb_pad
  import pinmux_arb_pkg::*;
#(
  parameter int GW = GW_DEFAULT
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          periph_req_i,
  input  logic          periph_o_i,
  input  logic          gpio_o_i,
  input  logic          gpio_oe_i,
  input  logic          lock_i,
  input  logic [GW-1:0] guard_cycles_i,
  output logic          pad_out_o,
  output logic          pad_oeb_o,
  output logic          periph_gnt_o
);

  pad_state_e    r_state;
  pad_state_e    w_state_next;
  logic [GW-1:0] r_cnt;
  logic [GW-1:0] w_cnt_next;
  logic          w_release;
  logic          w_guard_zero;
  logic          w_cnt_last;

  assign w_release    = ~periph_req_i | lock_i;
  assign w_guard_zero = (guard_cycles_i == '0);
  // A BRK state is only entered with a non-zero count; <=1 keeps it from
  // ever wrapping if that assumption were broken.
  assign w_cnt_last   = (r_cnt <= GW'(1));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= OWN_GPIO;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    unique case (r_state)
      OWN_GPIO: begin
        if (periph_req_i && !lock_i) begin
          if (w_guard_zero) begin
            w_state_next = OWN_PERIPH;
          end else begin
            w_state_next = BRK_P;
            w_cnt_next   = guard_cycles_i;
          end
        end
      end
      BRK_P: begin
        if (w_release) begin
          w_state_next = OWN_GPIO;
          w_cnt_next   = '0;
        end else if (w_cnt_last) begin
          w_state_next = OWN_PERIPH;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next   = r_cnt - GW'(1);
        end
      end
      OWN_PERIPH: begin
        if (w_release) begin
          if (w_guard_zero) begin
            w_state_next = OWN_GPIO;
          end else begin
            w_state_next = BRK_G;
            w_cnt_next   = guard_cycles_i;
          end
        end
      end
      BRK_G: begin
        // Handback always runs to completion; requests wait for OWN_GPIO.
        if (w_cnt_last) begin
          w_state_next = OWN_GPIO;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next   = r_cnt - GW'(1);
        end
      end
      default: begin
        w_state_next = OWN_GPIO;
        w_cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    pad_out_o    = 1'b0;
    pad_oeb_o    = 1'b1;
    periph_gnt_o = 1'b0;
    unique case (r_state)
      OWN_GPIO: begin
        pad_out_o = gpio_o_i;
        pad_oeb_o = ~gpio_oe_i;
      end
      OWN_PERIPH: begin
        pad_out_o    = periph_o_i;
        pad_oeb_o    = 1'b0;
        periph_gnt_o = 1'b1;
      end
      default: begin
        pad_out_o    = 1'b0;
        pad_oeb_o    = 1'b1;
        periph_gnt_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/pinmux_arbiter.sv
// NPIN shared pads arbitrated between a peripheral and GPIO. Optional
// saturating conflict counter when PINMUX_CONFLICT_CNT_EN is defined.
module pinmux_arbiter
  import pinmux_arb_pkg::*;
#(
  parameter int NPIN = NPIN_DEFAULT,
  parameter int GW   = GW_DEFAULT
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NPIN-1:0]           periph_req_i,
  input  logic [NPIN-1:0]           periph_o_i,
  input  logic [NPIN-1:0]           gpio_o_i,
  input  logic [NPIN-1:0]           gpio_oe_i,
  input  logic [NPIN-1:0]           lock_i,
  input  logic [GW-1:0]             guard_cycles_i,
  output logic [NPIN-1:0]           pad_out_o,
  output logic [NPIN-1:0]           pad_oeb_o,
  output logic [NPIN-1:0]           periph_gnt_o
`ifdef PINMUX_CONFLICT_CNT_EN
  ,
  input  logic                      conflict_clr_i,
  output logic [CONFLICT_CNT_W-1:0] conflict_cnt_o
`endif
);

  for (genvar gi = 0; gi < NPIN; gi++) begin : g_pad
    pinmux_arb_pad #(
      .GW(GW)
    ) u_pad (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .periph_req_i   (periph_req_i[gi]),
      .periph_o_i     (periph_o_i[gi]),
      .gpio_o_i       (gpio_o_i[gi]),
      .gpio_oe_i      (gpio_oe_i[gi]),
      .lock_i         (lock_i[gi]),
      .guard_cycles_i (guard_cycles_i),
      .pad_out_o      (pad_out_o[gi]),
      .pad_oeb_o      (pad_oeb_o[gi]),
      .periph_gnt_o   (periph_gnt_o[gi])
    );
  end

`ifdef PINMUX_CONFLICT_CNT_EN
  logic                      w_conflict;
  logic [CONFLICT_CNT_W-1:0] r_conflict_cnt;

  // Grant is high exactly in OWN_PERIPH, so it doubles as the state decode.
  assign w_conflict = |(periph_gnt_o & gpio_oe_i);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_conflict_cnt <= '0;
    end else if (conflict_clr_i) begin
      r_conflict_cnt <= '0;
    end else if (w_conflict && (r_conflict_cnt != {CONFLICT_CNT_W{1'b1}})) begin
      r_conflict_cnt <= r_conflict_cnt + CONFLICT_CNT_W'(1);
    end
  end

  assign conflict_cnt_o = r_conflict_cnt;
`endif

endmodule

// File: tb/tb_pinmux_arbiter.sv
// Self-checking bench for pinmux_arbiter: directed scenarios plus random
// traffic compared against a cycle-level ownership model.
module tb_pinmux_arbiter;

  localparam int NPIN = 5;
  localparam int GW   = 4;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic [NPIN-1:0] periph_req_i = '0;
  logic [NPIN-1:0] periph_o_i = '0;
  logic [NPIN-1:0] gpio_o_i = '0;
  logic [NPIN-1:0] gpio_oe_i = '0;
  logic [NPIN-1:0] lock_i = '0;
  logic [GW-1:0]   guard_cycles_i = '0;
  logic [NPIN-1:0] pad_out_o;
  logic [NPIN-1:0] pad_oeb_o;
  logic [NPIN-1:0] periph_gnt_o;
  logic            conflict_clr_i = 1'b0;
  logic [15:0]     conflict_cnt_o;

  int total = 0;
  int bad = 0;

  // Model: owner (0 gpio / 1 periph), remaining hi-Z cycles, and direction
  // of the pending handover (1 = towards peripheral).
  int m_own[NPIN];
  int m_hiz[NPIN];
  int m_dir[NPIN];
  int m_cnt;

  pinmux_arbiter #(.NPIN(NPIN), .GW(GW)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .periph_req_i   (periph_req_i),
    .periph_o_i     (periph_o_i),
    .gpio_o_i       (gpio_o_i),
    .gpio_oe_i      (gpio_oe_i),
    .lock_i         (lock_i),
    .guard_cycles_i (guard_cycles_i),
    .pad_out_o      (pad_out_o),
    .pad_oeb_o      (pad_oeb_o),
    .periph_gnt_o   (periph_gnt_o)
`ifdef PINMUX_CONFLICT_CNT_EN
    ,
    .conflict_clr_i (conflict_clr_i),
    .conflict_cnt_o (conflict_cnt_o)
`endif
  );

`ifndef PINMUX_CONFLICT_CNT_EN
  assign conflict_cnt_o = '0;
`endif

  always #5 clk_i = ~clk_i;

  task automatic model_edge();
    bit conf = 0;
    int g = int'(guard_cycles_i);
    for (int p = 0; p < NPIN; p++)
      if (m_hiz[p] == 0 && m_own[p] == 1 && gpio_oe_i[p]) conf = 1;
    if (!rst_ni) m_cnt = 0;
    else if (conflict_clr_i) m_cnt = 0;
    else if (conf && m_cnt < 65535) m_cnt++;
    for (int p = 0; p < NPIN; p++) begin
      bit rel = !periph_req_i[p] || lock_i[p];
      if (!rst_ni) begin
        m_own[p] = 0; m_hiz[p] = 0; m_dir[p] = 0;
      end else if (m_hiz[p] > 0) begin
        if (m_dir[p] == 1 && rel) begin
          m_hiz[p] = 0; m_own[p] = 0;
        end else begin
          m_hiz[p]--;
          if (m_hiz[p] == 0) m_own[p] = m_dir[p];
        end
      end else if (m_own[p] == 0) begin
        if (!rel) begin
          if (g == 0) m_own[p] = 1;
          else begin m_hiz[p] = g; m_dir[p] = 1; end
        end
      end else if (rel) begin
        m_own[p] = 0;
        if (g > 0) begin m_hiz[p] = g; m_dir[p] = 0; end
      end
    end
  endtask

  task automatic model_outs(output logic [NPIN-1:0] eo, output logic [NPIN-1:0] eoeb,
                            output logic [NPIN-1:0] eg);
    for (int p = 0; p < NPIN; p++) begin
      if (m_hiz[p] > 0) begin
        eo[p] = 0; eoeb[p] = 1; eg[p] = 0;
      end else if (m_own[p] == 1) begin
        eo[p] = periph_o_i[p]; eoeb[p] = 0; eg[p] = 1;
      end else begin
        eo[p] = gpio_o_i[p]; eoeb[p] = ~gpio_oe_i[p]; eg[p] = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 0;
    gpio_o_i = 5'b10110;
    gpio_oe_i = 5'b01101;
    tick();
    rst_ni = 1;
    #1;
    total++; if (periph_gnt_o !== 5'b0) begin bad++; $display("FAIL reset_gnt got=%b want=%b", periph_gnt_o, 5'b0); end
    total++; if (pad_oeb_o !== 5'b10010) begin bad++; $display("FAIL reset_oeb got=%b want=%b", pad_oeb_o, 5'b10010); end
    total++; if (pad_out_o !== 5'b10110) begin bad++; $display("FAIL reset_out got=%b want=%b", pad_out_o, 5'b10110); end
`ifdef PINMUX_CONFLICT_CNT_EN
    total++; if (conflict_cnt_o !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", conflict_cnt_o); end
`endif
  endtask

  task automatic test_grant_seq();
    gpio_oe_i = 5'b11111;
    guard_cycles_i = 4'd3;
    periph_req_i[0] = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (pad_oeb_o[0] !== 1'b1 || periph_gnt_o[0] !== 1'b0) begin
        bad++; $display("FAIL grant_brk%0d got oeb=%b gnt=%b want oeb=1 gnt=0", i, pad_oeb_o[0], periph_gnt_o[0]);
      end
    end
    tick();
    periph_o_i[0] = 1;
    #1;
    total++; if (periph_gnt_o[0] !== 1'b1 || pad_oeb_o[0] !== 1'b0 || pad_out_o[0] !== 1'b1) begin
      bad++; $display("FAIL grant_own got gnt=%b oeb=%b out=%b want 1 0 1", periph_gnt_o[0], pad_oeb_o[0], pad_out_o[0]);
    end
    periph_o_i[0] = 0;
    #1;
    total++; if (pad_out_o[0] !== 1'b0) begin bad++; $display("FAIL grant_follow got=%b want=0", pad_out_o[0]); end
  endtask

  task automatic test_release();
    guard_cycles_i = 4'd2;
    gpio_oe_i = 5'b00000;
    periph_req_i[0] = 0;
    tick();
    total++; if (pad_oeb_o[0] !== 1'b1 || periph_gnt_o[0] !== 1'b0) begin
      bad++; $display("FAIL release_brk0 got oeb=%b gnt=%b want 1 0", pad_oeb_o[0], periph_gnt_o[0]);
    end
    periph_req_i[0] = 1;
    tick();
    total++; if (pad_oeb_o[0] !== 1'b1 || periph_gnt_o[0] !== 1'b0) begin
      bad++; $display("FAIL release_brk1 got oeb=%b gnt=%b want 1 0", pad_oeb_o[0], periph_gnt_o[0]);
    end
    tick();
    total++; if (pad_oeb_o[0] !== 1'b1 || periph_gnt_o[0] !== 1'b0 || pad_out_o[0] !== gpio_o_i[0]) begin
      bad++; $display("FAIL release_gpio got oeb=%b gnt=%b out=%b want 1 0 %b", pad_oeb_o[0], periph_gnt_o[0], pad_out_o[0], gpio_o_i[0]);
    end
    gpio_oe_i[0] = 1;
    #1;
    total++; if (pad_oeb_o[0] !== 1'b0) begin bad++; $display("FAIL release_gpio_oe got=%b want=0", pad_oeb_o[0]); end
    tick();
    total++; if (pad_oeb_o[0] !== 1'b1 || periph_gnt_o[0] !== 1'b0) begin
      bad++; $display("FAIL release_rereq got oeb=%b gnt=%b want 1 0", pad_oeb_o[0], periph_gnt_o[0]);
    end
    periph_req_i[0] = 0;
    tick();
    total++; if (pad_oeb_o[0] !== 1'b0 || periph_gnt_o[0] !== 1'b0) begin
      bad++; $display("FAIL release_abort got oeb=%b gnt=%b want 0 0", pad_oeb_o[0], periph_gnt_o[0]);
    end
  endtask

  task automatic test_abort();
    int gnt_seen = 0;
    guard_cycles_i = 4'd4;
    gpio_oe_i = 5'b00001;
    periph_req_i[0] = 1;
    tick(); gnt_seen += periph_gnt_o[0];
    tick(); gnt_seen += periph_gnt_o[0];
    total++; if (pad_oeb_o[0] !== 1'b1) begin bad++; $display("FAIL abort_brk got oeb=%b want=1", pad_oeb_o[0]); end
    periph_req_i[0] = 0;
    tick(); gnt_seen += periph_gnt_o[0];
    total++; if (pad_oeb_o[0] !== 1'b0) begin bad++; $display("FAIL abort_gpio got oeb=%b want=0", pad_oeb_o[0]); end
    for (int i = 0; i < 6; i++) begin tick(); gnt_seen += periph_gnt_o[0]; end
    total++; if (gnt_seen != 0) begin bad++; $display("FAIL abort_gnt got=%0d grant cycles want=0", gnt_seen); end
  endtask

  task automatic test_lock();
    guard_cycles_i = 4'd0;
    gpio_oe_i = 5'b00011;
    gpio_o_i = 5'b00001;
    periph_req_i = 5'b00011;
    tick();
    total++; if (periph_gnt_o !== 5'b00011) begin bad++; $display("FAIL lock_own got=%b want=%b", periph_gnt_o, 5'b00011); end
    lock_i[0] = 1;
    tick();
    total++; if (periph_gnt_o !== 5'b00010) begin bad++; $display("FAIL lock_gnt got=%b want=%b", periph_gnt_o, 5'b00010); end
    total++; if (pad_oeb_o[1:0] !== 2'b00 || pad_out_o[0] !== 1'b1) begin
      bad++; $display("FAIL lock_pad got oeb=%b out0=%b want 00 1", pad_oeb_o[1:0], pad_out_o[0]);
    end
    periph_req_i = '0;
    lock_i = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    guard_cycles_i = 4'd0;
    gpio_oe_i = 5'b00000;
    periph_req_i = 5'b00001;
    tick();
    guard_cycles_i = 4'd5;
    periph_req_i = 5'b00101;
    tick();
    total++; if (pad_oeb_o[2] !== 1'b1 || periph_gnt_o !== 5'b00001) begin
      bad++; $display("FAIL rstmid_pre got oeb2=%b gnt=%b want 1 00001", pad_oeb_o[2], periph_gnt_o);
    end
    rst_ni = 0;
    tick();
    rst_ni = 1;
    gpio_oe_i[2] = 1;
    #1;
    total++; if (periph_gnt_o !== 5'b0) begin bad++; $display("FAIL rstmid_gnt got=%b want=00000", periph_gnt_o); end
    total++; if (pad_oeb_o[2] !== 1'b0) begin bad++; $display("FAIL rstmid_gpio got oeb2=%b want=0", pad_oeb_o[2]); end
`ifdef PINMUX_CONFLICT_CNT_EN
    total++; if (conflict_cnt_o !== 16'd0) begin bad++; $display("FAIL rstmid_cnt got=%0d want=0", conflict_cnt_o); end
`endif
    periph_req_i = '0;
    gpio_oe_i = '0;
    for (int i = 0; i < 8; i++) tick();
  endtask

`ifdef PINMUX_CONFLICT_CNT_EN
  task automatic test_conflict();
    rst_ni = 0; tick(); rst_ni = 1;
    guard_cycles_i = 4'd0;
    periph_req_i = 5'b00001;
    tick();
    gpio_oe_i = 5'b00001;
    for (int i = 0; i < 5; i++) tick();
    gpio_oe_i = '0;
    tick();
    total++; if (conflict_cnt_o !== 16'd5) begin bad++; $display("FAIL conflict_five got=%0d want=5", conflict_cnt_o); end
    gpio_oe_i = 5'b00001;
    conflict_clr_i = 1;
    tick();
    conflict_clr_i = 0;
    total++; if (conflict_cnt_o !== 16'd0) begin bad++; $display("FAIL conflict_clr got=%0d want=0", conflict_cnt_o); end
    for (int i = 0; i < 65540; i++) tick();
    total++; if (conflict_cnt_o !== 16'hFFFF) begin bad++; $display("FAIL conflict_sat got=%h want=ffff", conflict_cnt_o); end
    gpio_oe_i = '0;
    periph_req_i = '0;
    conflict_clr_i = 1;
    tick();
    conflict_clr_i = 0;
    tick();
  endtask
`endif

  task automatic test_random();
    logic [NPIN-1:0] eo, eoeb, eg;
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < NPIN; p++) begin
        if ($urandom_range(7) == 0) periph_req_i[p] = ~periph_req_i[p];
        lock_i[p] = ($urandom_range(15) == 0);
      end
      guard_cycles_i = GW'($urandom_range(3));
      periph_o_i = NPIN'($urandom);
      gpio_o_i = NPIN'($urandom);
      gpio_oe_i = NPIN'($urandom);
`ifdef PINMUX_CONFLICT_CNT_EN
      conflict_clr_i = ($urandom_range(31) == 0);
`endif
      tick();
      model_outs(eo, eoeb, eg);
      total++; if (periph_gnt_o !== eg) begin bad++; $display("FAIL rand_gnt c=%0d got=%b want=%b", c, periph_gnt_o, eg); end
      total++; if (pad_oeb_o !== eoeb) begin bad++; $display("FAIL rand_oeb c=%0d got=%b want=%b", c, pad_oeb_o, eoeb); end
      total++; if (pad_out_o !== eo) begin bad++; $display("FAIL rand_out c=%0d got=%b want=%b", c, pad_out_o, eo); end
`ifdef PINMUX_CONFLICT_CNT_EN
      total++; if (conflict_cnt_o !== 16'(m_cnt)) begin bad++; $display("FAIL rand_cnt c=%0d got=%0d want=%0d", c, conflict_cnt_o, m_cnt); end
`endif
    end
    conflict_clr_i = 0;
  endtask

  initial begin
    for (int p = 0; p < NPIN; p++) begin m_own[p] = 0; m_hiz[p] = 0; m_dir[p] = 0; end
    m_cnt = 0;
    test_reset();
    test_grant_seq();
    test_release();
    test_abort();
    test_lock();
    test_reset_mid();
`ifdef PINMUX_CONFLICT_CNT_EN
    test_conflict();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
